// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/aux RAM arbiter.
// No logic; widths and enums only.
// Imported by mem_arbiter and arb_wait_counter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_WAIT_DEF = 4;
    localparam int CNT_W        = 4;

    typedef enum logic {
        CPU_PRI,
        AUX_PRI
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_AUX
    } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the aux port has been denied.
// Latency: count updates at the clock edge after inc/clr.
// Backpressure: none; clr has priority over inc, count holds at MAX_WAIT.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    assign at_max = (count == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU, aux) onto a single-port RAM with starvation guard for aux.
// Latency: grant and RAM drive combinational; read data returns one cycle after grant.
// Backpressure: losing CPU sees cpu_stall, losing aux sees aux_gnt low; one access per cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t        state;
    owner_t            owner_q;
    logic              cpu_gnt;
    logic              wait_inc;
    logic              wait_clr;
    logic              wait_at_max;
    logic              wait_reach;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] aux_rdata_q;

    // Grants are masked by rst_n so nothing reaches the RAM while in reset.
    assign cpu_gnt   = rst_n && cpu_req && !(aux_req && (state == AUX_PRI));
    assign aux_gnt   = rst_n && aux_req && !(cpu_req && (state == CPU_PRI));
    assign cpu_stall = cpu_req && !cpu_gnt;

    assign wait_inc   = aux_req && !aux_gnt;
    assign wait_clr   = !aux_req || aux_gnt;
    // Flip priority on the edge where the counter lands on MAX_WAIT so aux wins the very next cycle.
    assign wait_reach = wait_inc && !wait_at_max && (wait_cnt == CNT_W'(MAX_WAIT - 1));

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (wait_inc),
        .clr    (wait_clr),
        .count  (wait_cnt),
        .at_max (wait_at_max)
    );

    assign ram_addr  = cpu_gnt ? cpu_addr  : (aux_gnt ? aux_addr  : addr_q);
    assign ram_wdata = cpu_gnt ? cpu_wdata : (aux_gnt ? aux_wdata : wdata_q);
    assign ram_wren  = (cpu_gnt && cpu_we) || (aux_gnt && aux_we);

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign aux_rvalid = (owner_q == OWN_AUX);
    assign cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_q;
    assign aux_rdata  = aux_rvalid ? ram_q : aux_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CPU_PRI;
        end else begin
            case (state)
                CPU_PRI: if (wait_reach)           state <= AUX_PRI;
                AUX_PRI: if (aux_gnt || !aux_req)  state <= CPU_PRI;
                default:                           state <= CPU_PRI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            if (cpu_gnt && !cpu_we)      owner_q <= OWN_CPU;
            else if (aux_gnt && !aux_we) owner_q <= OWN_AUX;
            else                         owner_q <= OWN_NONE;
            if (cpu_gnt || aux_gnt) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
            end
            if (cpu_rvalid) cpu_rdata_q <= ram_q;
            if (aux_rvalid) aux_rdata_q <= ram_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 1-cycle RAM, directed steps with hand-computed
// expectations, read responses checked by a separate scoreboard monitor.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, aux_req, aux_we;
    logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
    logic        cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid, ram_wren;
    logic [15:0] cpu_rdata, aux_rdata, ram_addr, ram_wdata, ram_q;

    logic [15:0] mem [0:65535];

    typedef struct {
        int          own;
        logic [15:0] dat;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [15:0] last_c = '0;
    logic [15:0] last_a = '0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (aux_gnt),
        .aux_rdata  (aux_rdata),
        .aux_rvalid (aux_rvalid),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM; a write at edge N is visible to a read issued in cycle N+1.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
        cyc   <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops the response due this cycle and checks both read ports.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_c = '0;
            last_a = '0;
        end else begin
            exp_t e;
            int   own;
            own = 0;
            e   = '{0, 16'h0, 0};
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e   = sb.pop_front();
                own = e.own;
            end
            chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, own == 1});
            chk("aux_rvalid", {31'd0, aux_rvalid}, {31'd0, own == 2});
            if (own == 1) last_c = e.dat;
            if (own == 2) last_a = e.dat;
            chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, last_c});
            chk("aux_rdata", {16'd0, aux_rdata}, {16'd0, last_a});
        end
    end

    task automatic step(
        input logic creq, input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
        input logic areq, input logic awe, input logic [15:0] aaddr, input logic [15:0] awd,
        input logic e_stall, input logic e_gnt, input logic e_wren,
        input logic [15:0] e_addr, input logic [15:0] e_wdat,
        input int push_own, input logic [15:0] push_dat
    );
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        aux_req = areq; aux_we = awe; aux_addr = aaddr; aux_wdata = awd;
        if (push_own != 0) sb.push_back('{push_own, push_dat, cyc + 1});
        @(negedge clk);
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
        chk("aux_gnt",   {31'd0, aux_gnt},   {31'd0, e_gnt});
        chk("ram_wren",  {31'd0, ram_wren},  {31'd0, e_wren});
        chk("ram_addr",  {16'd0, ram_addr},  {16'd0, e_addr});
        if (e_wren) chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, e_wdat});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] e_addr);
        step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, e_addr, 16'h0, 0, 16'h0);
    endtask

    task automatic reset_check();
        @(negedge clk);
        chk("rst cpu_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rst aux_gnt",   {31'd0, aux_gnt},   32'd0);
        chk("rst ram_wren",  {31'd0, ram_wren},  32'd0);
        chk("rst ram_addr",  {16'd0, ram_addr},  32'd0);
        chk("rst ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst rvalids",   {30'd0, cpu_rvalid, aux_rvalid}, 32'd0);
        chk("rst cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst aux_rdata", {16'd0, aux_rdata}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0; aux_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        reset_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload RAM[2] then CPU read alone.
        step(1, 1, 16'h0002, 16'h00FF, 0, 0, 16'h0, 16'h0, 0, 0, 1, 16'h0002, 16'h00FF, 0, 16'h0);
        step(1, 0, 16'h0002, 16'h0,    0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0002, 16'h0,    1, 16'h00FF);
        idle(16'h0002);

        // CPU write then aux read of the same address on the next cycle.
        step(1, 1, 16'h0010, 16'hAAAA, 0, 0, 16'h0,    16'h0, 0, 0, 1, 16'h0010, 16'hAAAA, 0, 16'h0);
        step(0, 0, 16'h0,    16'h0,    1, 0, 16'h0010, 16'h0, 0, 1, 0, 16'h0010, 16'h0,    2, 16'hAAAA);
        idle(16'h0010);

        // Aux write alone, then CPU reads it back.
        step(0, 0, 16'h0,    16'h0, 1, 1, 16'h0003, 16'h5555, 0, 1, 1, 16'h0003, 16'h5555, 0, 16'h0);
        step(1, 0, 16'h0003, 16'h0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 16'h0003, 16'h0,    1, 16'h5555);

        // Alternating owners every cycle, no idle between.
        step(0, 0, 16'h0,    16'h0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 16'h0002, 16'h0, 2, 16'h00FF);
        step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0,    16'h0, 0, 0, 0, 16'h0010, 16'h0, 1, 16'hAAAA);
        step(0, 0, 16'h0,    16'h0, 1, 0, 16'h0003, 16'h0, 0, 1, 0, 16'h0003, 16'h0, 2, 16'h5555);
        idle(16'h0003);

        // Continuous contention: aux starves four cycles, wins the fifth.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                step(1, 0, 16'h0002, 16'h0, 1, 0, 16'h0003, 16'h0, 1, 1, 0, 16'h0003, 16'h0, 2, 16'h5555);
            else
                step(1, 0, 16'h0002, 16'h0, 1, 0, 16'h0003, 16'h0, 0, 0, 0, 16'h0002, 16'h0, 1, 16'h00FF);
        end
        idle(16'h0003);

        // Granted aux read, then reset in the following cycle: its response must vanish.
        step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0, 0, 1, 0, 16'h0010, 16'h0, 0, 16'h0);
        rst_n = 1'b0;
        cpu_req = 1'b1; aux_req = 1'b1;
        reset_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(16'h0000);
        // Back in CPU_PRI: CPU wins the first conflict.
        step(1, 0, 16'h0002, 16'h0, 1, 0, 16'h0003, 16'h0, 0, 0, 0, 16'h0002, 16'h0, 1, 16'h00FF);
        idle(16'h0002);
        idle(16'h0002);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 16, RAM word-address width.
  DATA_W, 16, data width.
  MAX_WAIT, 4, max consecutive cycles aux may be denied (1..15).
REQ-002 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-003 Ports SHALL be, one per line:
  clk  in  1  clock, rising edge
  rst_n  in  1  async active-low reset
  cpu_req  in  1  memory-stage access request
  cpu_we  in  1  1=write, 0=read
  cpu_addr  in  ADDR_W  word address
  cpu_wdata  in  DATA_W  store data
  cpu_stall  out  1  CPU request not granted this cycle; pipeline holds
  cpu_rdata  out  DATA_W  load data
  cpu_rvalid  out  1  cpu_rdata valid
  aux_req  in  1  auxiliary-port request (loader/display reader)
  aux_we  in  1  1=write, 0=read
  aux_addr  in  ADDR_W  word address
  aux_wdata  in  DATA_W  write data
  aux_gnt  out  1  aux request accepted this cycle
  aux_rdata  out  DATA_W  read data
  aux_rvalid  out  1  aux_rdata valid
  ram_addr  out  ADDR_W  drives both RAM rdaddress and wraddress
  ram_wdata  out  DATA_W  RAM data
  ram_wren  out  1  RAM write enable
  ram_q  in  DATA_W  RAM read data, 1-cycle latency

Function
REQ-004 Grant SHALL be combinational from requests and state; at most one requester granted per cycle.
REQ-005 FSM states SHALL be CPU_PRI (CPU wins conflicts) and AUX_PRI (aux wins conflicts).
REQ-006 CPU_PRI -> AUX_PRI SHALL occur when wait_cnt reaches MAX_WAIT; AUX_PRI -> CPU_PRI on any aux grant or aux_req low.
REQ-007 wait_cnt SHALL increment each cycle aux_req=1 and aux_gnt=0, clear when aux granted or aux_req=0, saturate at MAX_WAIT.
REQ-008 With only one requester active, it SHALL be granted regardless of state.
REQ-009 Granted requester's addr/wdata/we SHALL drive ram_addr/ram_wdata/ram_wren same cycle; no grant -> ram_wren=0, ram_addr/ram_wdata hold last value.
REQ-010 cpu_stall SHALL equal cpu_req AND NOT cpu granted.
REQ-011 A granted read in cycle N SHALL raise the owner's rvalid in cycle N+1 only, with rdata=ram_q; owner tag registered at edge ending N.
REQ-012 rdata outputs SHALL route ram_q only to the tagged owner; the other port's rdata holds its last value.
REQ-013 Granted writes SHALL produce no rvalid.
REQ-014 Back-to-back grants SHALL sustain one access per cycle; no bubbles inserted.
REQ-015 Write then read of same address in consecutive cycles by different requesters SHALL return the new data (RAM new-data mode); no forwarding in the arbiter.

Reset
REQ-016 On rst_n=0: state=CPU_PRI, wait_cnt=0, owner tag cleared, ram_wren=0, ram_addr=0, ram_wdata=0, cpu_rvalid=aux_rvalid=0, cpu_rdata=aux_rdata=0.
REQ-017 Reset mid-operation SHALL drop any pending rvalid; no access SHALL issue in the first cycle after release unless requested.
REQ-018 During reset aux_gnt=0; cpu_stall=cpu_req.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the arb_state_t enum (CPU_PRI, AUX_PRI), owner_t enum (OWN_NONE, OWN_CPU, OWN_AUX) and default-width constants.
REQ-020 The saturating wait counter SHALL be a sub-module arb_wait_counter (inputs inc, clr; output count, at_max).

Verification
REQ-021 CPU read 0x0002 alone, RAM[2]=0x00FF -> cpu_stall=0, ram_addr=0x0002, cpu_rvalid=1 with cpu_rdata=0x00FF next cycle, aux_rvalid=0.
REQ-022 cpu_req and aux_req held continuously, MAX_WAIT=4 -> aux denied cycles 0-3, aux_gnt=1 and cpu_stall=1 in cycle 4, CPU regains grant cycle 5, pattern repeats.
REQ-023 CPU write 0xAAAA to 0x0010 cycle N, aux read 0x0010 cycle N+1 -> aux_rvalid=1, aux_rdata=0xAAAA in N+2.
REQ-024 Alternating CPU/aux reads every cycle -> one rvalid per cycle, each to correct owner, zero idle cycles.
REQ-025 rst_n pulsed low in cycle after a granted aux read -> aux_rvalid never asserts, all outputs at reset values, state CPU_PRI after release.
REQ-026 aux_req alone with we=1, 0x5555 to 0x0003 -> aux_gnt=1, ram_wren=1 one cycle, no rvalid; subsequent CPU read 0x0003 returns 0x5555.
